// File: rtl/serdes_align_ctrl_if.sv
// ----------------------------------------------------------------------------
// serdes_align_ctrl_if
// Bundles the training controller's control/status signals toward the IDDR
// gearbox and the SerDes PLL dynamic phase shifter.
//   master : the alignment controller (drives IDDR/PLL controls and status)
//   slave  : the environment (drives train_en, PLL lock, IDDR ready/data)
// Signals:
//   train_en, pll_lock, iddr_ready, iddr_q[3:0]          -> controller
//   iddr_start, iddr_alignwd                             -> IDDR
//   pll_phasesel[1:0], pll_phasedir, pll_phasestep,
//   pll_phaseloadreg                                     -> PLL
//   busy, done, fail, phase_cur, best_start, best_len    -> status
// ----------------------------------------------------------------------------
interface serdes_align_ctrl_if #(
    parameter int PHASE_W = 3
);
    logic               train_en;
    logic               pll_lock;
    logic               iddr_ready;
    logic [3:0]         iddr_q;
    logic               iddr_start;
    logic               iddr_alignwd;
    logic [1:0]         pll_phasesel;
    logic               pll_phasedir;
    logic               pll_phasestep;
    logic               pll_phaseloadreg;
    logic               busy;
    logic               done;
    logic               fail;
    logic [PHASE_W-1:0] phase_cur;
    logic [PHASE_W-1:0] best_start;
    logic [PHASE_W:0]   best_len;

    modport master (
        input  train_en, pll_lock, iddr_ready, iddr_q,
        output iddr_start, iddr_alignwd, pll_phasesel, pll_phasedir,
               pll_phasestep, pll_phaseloadreg, busy, done, fail,
               phase_cur, best_start, best_len
    );

    modport slave (
        output train_en, pll_lock, iddr_ready, iddr_q,
        input  iddr_start, iddr_alignwd, pll_phasesel, pll_phasedir,
               pll_phasestep, pll_phaseloadreg, busy, done, fail,
               phase_cur, best_start, best_len
    );
endinterface

// File: rtl/serdes_align_ctrl.sv
// ----------------------------------------------------------------------------
// serdes_align_ctrl
// Training sequencer for the 4:1 IDDR receive path and the SerDes PLL dynamic
// phase shifter. Waits for PLL lock, starts the gearbox, sweeps the PLL phase
// over one revolution trying every word alignment at each phase, records the
// longest run of good phases, parks the phase at the centre of that run,
// re-aligns the word and reports done or fail.
// Ports:
//   sync_clk    : clock (IDDR sclk domain)
//   sync_reset  : synchronous active-high reset
//   bus         : serdes_align_ctrl_if master (IDDR/PLL controls, status)
// ----------------------------------------------------------------------------
module serdes_align_ctrl #(
    parameter int         PHASES     = 8,
    parameter int         PHASE_W    = 3,
    parameter logic [3:0] PATTERN    = 4'b1100,
    parameter int         CHECK_LEN  = 16,
    parameter int         SETTLE_CYC = 32,
    parameter int         MAX_SLIP   = 4,
    parameter int         STEP_HI    = 4,
    parameter logic [1:0] PHASESEL   = 2'd0
) (
    input  logic                 sync_clk,
    input  logic                 sync_reset,
    serdes_align_ctrl_if.master  bus
);

    localparam int CNT_W   = $clog2(STEP_HI + SETTLE_CYC + CHECK_LEN + 1);
    localparam int SLIP_W  = $clog2(MAX_SLIP + 1);
    localparam int STEPC_W = $clog2(STEP_HI + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WAIT_LOCK = 4'd1;
    localparam logic [3:0] S_START     = 4'd2;
    localparam logic [3:0] S_READY     = 4'd3;
    localparam logic [3:0] S_SETTLE    = 4'd4;
    localparam logic [3:0] S_CHECK     = 4'd5;
    localparam logic [3:0] S_SLIP      = 4'd6;
    localparam logic [3:0] S_EVAL      = 4'd7;
    localparam logic [3:0] S_STEP      = 4'd8;
    localparam logic [3:0] S_CENTER    = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;
    localparam logic [3:0] S_FAIL      = 4'd11;

    logic [3:0]         r_state;
    logic               r_train_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [SLIP_W-1:0]  r_slip;
    logic [PHASE_W-1:0] r_p;
    logic               r_sweep;      // 1 during the sweep pass, 0 while centring/verifying
    logic               r_ok;         // all words of the current check matched so far
    logic               r_good;
    logic [PHASE_W-1:0] r_run_start;
    logic [PHASE_W:0]   r_run_len;
    logic [PHASE_W-1:0] r_best_start;
    logic [PHASE_W:0]   r_best_len;
    logic [PHASE_W-1:0] r_phase;
    logic [STEPC_W-1:0] r_step_cnt;   // remaining high cycles of pll_phasestep
    logic               r_iddr_start;
    logic               r_alignwd;
    logic               r_done;
    logic               r_fail;

    logic               w_busy;
    logic               w_match;
    logic               w_pass;
    logic               w_check_last;
    logic               w_can_slip;
    logic [PHASE_W-1:0] w_phase_next;
    logic [PHASE_W:0]   w_run_len_next;
    logic [PHASE_W-1:0] w_run_start_next;
    logic [PHASE_W+1:0] w_sum;
    logic [PHASE_W-1:0] w_target;

    assign w_busy = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
    assign w_match      = (bus.iddr_q == PATTERN);
    assign w_pass       = r_ok & w_match;
    assign w_check_last = (r_cnt == CNT_W'(CHECK_LEN - 1));
    assign w_can_slip   = (r_slip < SLIP_W'(MAX_SLIP - 1));
    assign w_phase_next = (r_phase == PHASE_W'(PHASES - 1)) ? '0 : r_phase + 1'b1;
    assign w_run_len_next   = r_run_len + 1'b1;
    assign w_run_start_next = (r_run_len == '0) ? r_p : r_run_start;

    // Window centre, rounding toward the window start for even lengths.
    always_comb begin
        w_sum = {2'b00, r_best_start} + {1'b0, (r_best_len - 1'b1) >> 1};
        if (w_sum >= (PHASE_W+2)'(PHASES)) begin
            w_target = PHASE_W'(w_sum - (PHASE_W+2)'(PHASES));
        end else begin
            w_target = PHASE_W'(w_sum);
        end
    end

    always_ff @(posedge sync_clk) begin
        if (sync_reset) begin
            r_state      <= S_IDLE;
            r_train_d    <= 1'b0;
            r_cnt        <= '0;
            r_slip       <= '0;
            r_p          <= '0;
            r_sweep      <= 1'b0;
            r_ok         <= 1'b0;
            r_good       <= 1'b0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_phase      <= '0;
            r_step_cnt   <= '0;
            r_iddr_start <= 1'b0;
            r_alignwd    <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_train_d    <= bus.train_en;
            r_iddr_start <= 1'b0;
            r_alignwd    <= 1'b0;
            // The step pulse runs on its own so a lock loss cannot truncate it.
            if (r_step_cnt != '0) begin
                r_step_cnt <= r_step_cnt - 1'b1;
            end

            if (!bus.train_en) begin
                r_state    <= S_IDLE;
                r_step_cnt <= '0;
                r_done     <= 1'b0;
                r_fail     <= 1'b0;
            end else if (w_busy && !bus.pll_lock) begin
                // Relock returns the PLL to zero phase; discard the sweep.
                r_state      <= S_WAIT_LOCK;
                r_best_start <= '0;
                r_best_len   <= '0;
                r_run_start  <= '0;
                r_run_len    <= '0;
                r_p          <= '0;
                r_slip       <= '0;
                r_phase      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_train_d) begin
                            r_state <= S_WAIT_LOCK;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (bus.pll_lock) begin
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        r_iddr_start <= 1'b1;
                        r_p          <= '0;
                        r_slip       <= '0;
                        r_sweep      <= 1'b1;
                        r_run_start  <= '0;
                        r_run_len    <= '0;
                        r_best_start <= '0;
                        r_best_len   <= '0;
                        r_state      <= S_READY;
                    end
                    S_READY: begin
                        if (bus.iddr_ready) begin
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                            r_cnt   <= '0;
                            r_ok    <= 1'b1;
                            r_state <= S_CHECK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        r_ok <= r_ok & w_match;
                        if (w_check_last) begin
                            r_cnt <= '0;
                            if (w_pass) begin
                                if (r_sweep) begin
                                    r_good  <= 1'b1;
                                    r_state <= S_EVAL;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
                            end else if (w_can_slip) begin
                                r_state <= S_SLIP;
                            end else if (r_sweep) begin
                                r_good  <= 1'b0;
                                r_state <= S_EVAL;
                            end else begin
                                r_fail  <= 1'b1;
                                r_state <= S_FAIL;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SLIP: begin
                        r_alignwd <= 1'b1;
                        r_slip    <= r_slip + 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_SETTLE;
                    end
                    S_EVAL: begin
                        if (r_good) begin
                            r_run_len   <= w_run_len_next;
                            r_run_start <= w_run_start_next;
                            // Strict compare keeps the earliest window on a tie.
                            if (w_run_len_next > r_best_len) begin
                                r_best_len   <= w_run_len_next;
                                r_best_start <= w_run_start_next;
                            end
                        end else begin
                            r_run_len <= '0;
                        end
                        r_step_cnt <= STEPC_W'(STEP_HI);
                        r_phase    <= w_phase_next;
                        r_cnt      <= '0;
                        r_slip     <= '0;
                        r_state    <= S_STEP;
                    end
                    S_STEP: begin
                        // One counter covers the high time plus the settle wait.
                        if (r_cnt == CNT_W'(STEP_HI + SETTLE_CYC - 1)) begin
                            r_cnt <= '0;
                            r_ok  <= 1'b1;
                            if (!r_sweep || (r_phase == '0)) begin
                                r_state <= S_CENTER;
                            end else begin
                                r_p     <= r_p + 1'b1;
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_CENTER: begin
                        r_sweep <= 1'b0;
                        if (r_best_len == '0) begin
                            r_fail  <= 1'b1;
                            r_state <= S_FAIL;
                        end else if (r_phase == w_target) begin
                            r_slip  <= '0;
                            r_cnt   <= '0;
                            r_ok    <= 1'b1;
                            r_state <= S_CHECK;
                        end else begin
                            r_step_cnt <= STEPC_W'(STEP_HI);
                            r_phase    <= w_phase_next;
                            r_cnt      <= '0;
                            r_slip     <= '0;
                            r_state    <= S_STEP;
                        end
                    end
                    S_DONE: begin
                        r_done <= 1'b1;
                    end
                    S_FAIL: begin
                        r_fail <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.iddr_start       = r_iddr_start;
    assign bus.iddr_alignwd     = r_alignwd;
    assign bus.pll_phasesel     = PHASESEL;
    assign bus.pll_phasedir     = 1'b0;
    assign bus.pll_phasestep    = (r_step_cnt != '0);
    assign bus.pll_phaseloadreg = 1'b0;
    assign bus.busy             = w_busy;
    assign bus.done             = r_done;
    assign bus.fail             = r_fail;
    assign bus.phase_cur        = r_phase;
    assign bus.best_start       = r_best_start;
    assign bus.best_len         = r_best_len;

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serdes_align_ctrl
// Directed bench for serdes_align_ctrl. A small environment model plays the
// PLL (phase advances on each phasestep rising edge, returns to zero on
// reset or lock loss) and the IDDR (word alignment moves on alignwd and is
// re-randomised to zero by start or a phase step; ready follows start after
// a few cycles). Each vector gives the good-phase mask, the slips needed to
// align, an optional one-word glitch, and the expected final status.
// ----------------------------------------------------------------------------
module tb_serdes_align_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serdes_align_ctrl_if #(.PHASE_W(3)) bus ();

    serdes_align_ctrl #(
        .PHASES     (8),
        .PHASE_W    (3),
        .PATTERN    (4'b1100),
        .CHECK_LEN  (16),
        .SETTLE_CYC (32),
        .MAX_SLIP   (4),
        .STEP_HI    (4),
        .PHASESEL   (2'd0)
    ) u_dut (
        .sync_clk   (clk),
        .sync_reset (rst),
        .bus        (bus)
    );

    // ---------------- environment model ----------------
    logic [7:0] env_mask = 8'h00;
    int         env_need = 0;
    int         gl_phase = 99;
    int         gl_id    = 0;
    int         gl_fired = 0;

    logic [2:0] e_phase  = '0;
    int         e_align  = 0;
    int         e_since  = 1000;
    logic       e_step_d = 1'b0;
    int         rdy_cnt  = 5;
    int         n_step   = 0;
    int         n_slip   = 0;
    int         n_start  = 0;
    int         hi_cnt   = 0;
    int         last_w   = 0;
    logic       w_glitch;

    assign w_glitch = (e_since == 41) && (gl_id != gl_fired) && (int'(e_phase) == gl_phase);
    assign bus.iddr_q = (env_mask[e_phase] && (e_align == env_need) && !w_glitch) ? 4'b1100 : 4'b0110;
    assign bus.iddr_ready = (rdy_cnt >= 5);

    always @(posedge clk) begin
        e_step_d <= bus.pll_phasestep;
        if (bus.pll_phasestep && !e_step_d) begin
            n_step  <= n_step + 1;
            e_align <= 0;
        end
        if (rst || !bus.pll_lock) begin
            e_phase <= '0;
        end else if (bus.pll_phasestep && !e_step_d) begin
            e_phase <= e_phase + 3'd1;
        end
        if (bus.iddr_start) begin
            n_start <= n_start + 1;
            rdy_cnt <= 0;
            e_align <= 0;
        end else if (rdy_cnt < 5) begin
            rdy_cnt <= rdy_cnt + 1;
        end
        if (bus.iddr_alignwd) begin
            n_slip  <= n_slip + 1;
            e_align <= (e_align + 1) % 4;
            e_since <= 0;
        end else if (e_since < 1000) begin
            e_since <= e_since + 1;
        end
        if (w_glitch) begin
            gl_fired <= gl_id;
        end
        if (bus.pll_phasestep) begin
            hi_cnt <= hi_cnt + 1;
        end else begin
            if (e_step_d) last_w <= hi_cnt;
            hi_cnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] mask;
        int         need;
        int         glp;
        int         exp_done;
        int         exp_fail;
        int         exp_phase;
        int         exp_bs;
        int         exp_bl;
        int         exp_steps;
        int         exp_slips;
    } vec_t;

    vec_t vecs[8];
    int   base_step;
    int   base_slip;
    int   base_start;

    task automatic start_run(input logic [7:0] mask, input int need, input int glp);
        @(negedge clk);
        rst          = 1'b1;
        bus.train_en = 1'b0;
        bus.pll_lock = 1'b1;
        env_mask     = mask;
        env_need     = need;
        gl_phase     = glp;
        gl_id        = gl_id + 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base_step  = n_step;
        base_slip  = n_slip;
        base_start = n_start;
        bus.train_en = 1'b1;
    endtask

    task automatic wait_end(input string name);
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (bus.done || bus.fail) break;
        end
        chk({name, "_finished"}, int'(bus.done | bus.fail), 1);
    endtask

    task automatic wait_step_hi(input string name);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (bus.pll_phasestep) break;
        end
        chk({name, "_step_seen"}, int'(bus.pll_phasestep), 1);
    endtask

    initial begin
        bus.train_en = 1'b0;
        bus.pll_lock = 1'b1;

        //           mask          need glp done fail ph bs bl steps slips
        vecs[0] = '{8'b0011_1100, 1, 99, 1, 0, 3, 2, 4, 11, 17};
        vecs[1] = '{8'b0000_0000, 0, 99, 0, 1, 0, 0, 0,  8, 24};
        vecs[2] = '{8'b0111_0010, 0, 99, 1, 0, 5, 4, 3, 13, 12};
        vecs[3] = '{8'b0110_0110, 0, 99, 1, 0, 1, 1, 2,  9, 12};
        vecs[4] = '{8'b1100_0001, 0, 99, 1, 0, 6, 6, 2, 14, 15};
        vecs[5] = '{8'b1111_1111, 0, 99, 1, 0, 3, 0, 8, 11,  0};
        vecs[6] = '{8'b1111_1111, 3, 99, 1, 0, 3, 0, 8, 11, 27};
        vecs[7] = '{8'b1111_1111, 1,  4, 1, 0, 1, 0, 4,  9, 11};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",      int'(bus.busy), 0);
        chk("rst_done_fail", int'({bus.done, bus.fail}), 0);
        chk("rst_phase",     int'(bus.phase_cur), 0);
        chk("rst_best",      int'({bus.best_start, bus.best_len}), 0);
        chk("rst_pulses",    int'({bus.iddr_start, bus.iddr_alignwd, bus.pll_phasestep}), 0);
        chk("rst_pll_const", int'({bus.pll_phasesel, bus.pll_phasedir, bus.pll_phaseloadreg}), 0);

        // Table-driven full training runs
        for (int i = 0; i < 8; i++) begin
            start_run(vecs[i].mask, vecs[i].need, vecs[i].glp);
            wait_end($sformatf("v%0d", i));
            chk($sformatf("v%0d_done", i),   int'(bus.done), vecs[i].exp_done);
            chk($sformatf("v%0d_fail", i),   int'(bus.fail), vecs[i].exp_fail);
            chk($sformatf("v%0d_busy", i),   int'(bus.busy), 0);
            chk($sformatf("v%0d_phase", i),  int'(bus.phase_cur), vecs[i].exp_phase);
            chk($sformatf("v%0d_bstart", i), int'(bus.best_start), vecs[i].exp_bs);
            chk($sformatf("v%0d_blen", i),   int'(bus.best_len), vecs[i].exp_bl);
            chk($sformatf("v%0d_steps", i),  n_step - base_step, vecs[i].exp_steps);
            chk($sformatf("v%0d_slips", i),  n_slip - base_slip, vecs[i].exp_slips);
            chk($sformatf("v%0d_starts", i), n_start - base_start, 1);
        end
        chk("step_width", last_w, 4);

        // done is sticky until train_en drops; best_* survive for readout
        repeat (3) @(negedge clk);
        chk("done_sticky", int'(bus.done), 1);
        bus.train_en = 1'b0;
        @(negedge clk);
        chk("done_cleared", int'(bus.done), 0);
        chk("best_held",    int'(bus.best_len), 4);
        chk("phase_held",   int'(bus.phase_cur), 1);

        // Lock drop at p=3 during the sweep, then relock
        start_run(8'b0000_0110, 0, 99);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if ((n_step - base_step) == 3 && !bus.pll_phasestep) break;
        end
        repeat (5) @(negedge clk);
        chk("lk_pre_blen", int'(bus.best_len), 2);
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("lk_busy",  int'(bus.busy), 1);
        chk("lk_blen",  int'(bus.best_len), 0);
        chk("lk_phase", int'(bus.phase_cur), 0);
        repeat (5) @(negedge clk);
        base_step  = n_step;
        base_start = n_start;
        bus.pll_lock = 1'b1;
        wait_end("lk");
        chk("lk_restart", n_start - base_start, 1);
        chk("lk_done",    int'(bus.done), 1);
        chk("lk_bstart",  int'(bus.best_start), 1);
        chk("lk_blen2",   int'(bus.best_len), 2);
        chk("lk_phase2",  int'(bus.phase_cur), 1);
        chk("lk_steps",   n_step - base_step, 9);

        // train_en low in the middle of a step pulse
        start_run(8'hFF, 0, 99);
        wait_step_hi("ten");
        bus.train_en = 1'b0;
        @(posedge clk);
        #1;
        chk("ten_step_low", int'(bus.pll_phasestep), 0);
        chk("ten_idle",     int'(bus.busy), 0);
        chk("ten_phase",    int'(bus.phase_cur), 1);

        // sync_reset in the middle of a step pulse
        start_run(8'hFF, 0, 99);
        wait_step_hi("srst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("srst_step_low", int'(bus.pll_phasestep), 0);
        chk("srst_idle",     int'(bus.busy), 0);
        chk("srst_phase",    int'(bus.phase_cur), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.train_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
